// File: rtl/mem_stall_resp.sv
// mem_stall_resp: multi-cycle data-memory responder with Stall/Done
// handshake and a fixed, parameterised access latency.
module mem_stall_resp #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Rd,
  input  logic        Wr,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 2);

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_idx;
  logic [15:0]         r_din;
  logic [15:0]         r_dout;
  logic                r_done;
  logic                r_stall;
  logic                r_err;
  logic [15:0]         r_mem [DEPTH];

  logic                w_req;
  logic                w_legal;
  logic                w_commit;
  logic                w_unused_addr;

  assign w_req    = Rd | Wr;
  assign w_legal  = (Rd ^ Wr) & ~Addr[0];
  assign w_commit = (r_state == BUSY) && (r_cnt == 4'd0);
  // High address bits alias onto the same word.
  assign w_unused_addr = ^Addr[15:ADDR_W+1];

  // Request FSM: accept in IDLE/DONE, count down in BUSY, pulse Done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_wr    <= 1'b0;
      r_idx   <= '0;
      r_din   <= 16'h0000;
      r_dout  <= 16'h0000;
      r_done  <= 1'b0;
      r_stall <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        IDLE, DONE: begin
          if (w_legal) begin
            r_state <= BUSY;
            r_cnt   <= CNT_INIT;
            r_wr    <= Wr;
            r_idx   <= Addr[ADDR_W:1];
            r_din   <= DataIn;
            r_stall <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_stall <= 1'b0;
            r_err   <= w_req;
          end
        end
        BUSY: begin
          if (r_cnt == 4'd0) begin
            r_state <= DONE;
            r_stall <= 1'b0;
            r_done  <= 1'b1;
            if (!r_wr) begin
              r_dout <= r_mem[r_idx];
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset; a reset on the commit edge drops the write.
  always_ff @(posedge clk) begin
    if (!rst && w_commit && r_wr) begin
      r_mem[r_idx] <= r_din;
    end
  end

  assign DataOut = r_dout;
  assign Done    = r_done;
  assign Stall   = r_stall;
  assign err     = r_err;

endmodule

// File: tb/tb_mem_stall_resp.sv
// tb_mem_stall_resp: directed vector table, corner sequences and
// random traffic against a transaction-timing reference model.
module tb_mem_stall_resp;

  localparam int AW = 8;
  localparam int L  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Rd = 1'b0;
  logic        Wr = 1'b0;
  logic [15:0] Addr = 16'h0000;
  logic [15:0] DataIn = 16'h0000;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        err;

  mem_stall_resp #(.ADDR_W(AW), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .Rd(Rd), .Wr(Wr),
    .Addr(Addr), .DataIn(DataIn), .DataOut(DataOut),
    .Done(Done), .Stall(Stall), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          r, rd, wr;
    logic [15:0] a, d;
    bit          st, dn, er;
    logic [15:0] dout;
  } vec_t;
  vec_t tbl[$];

  // Reference model: one transaction, timed by its accept cycle.
  int          t = 0;
  bit          m_have = 0;
  int          m_tacc = 0;
  bit          m_wr = 0;
  int          m_idx = 0;
  logic [15:0] m_din;
  logic [15:0] m_mem [2**AW];
  logic [15:0] e_dout = 16'h0000;
  bit          e_stall, e_done, e_err;

  task automatic model_edge(input bit r, rd, wr,
                            input logic [15:0] a, d);
    e_err = 0;
    if (r) begin
      m_have = 0;
      e_dout = 16'h0000;
    end else begin
      if (m_have && t == m_tacc + L - 1) begin
        if (m_wr) m_mem[m_idx] = m_din;
        else e_dout = m_mem[m_idx];
      end
      if (!m_have || t >= m_tacc + L) begin
        if (rd || wr) begin
          if ((rd && wr) || a[0]) e_err = 1;
          else begin
            m_have = 1;
            m_tacc = t;
            m_wr   = wr;
            m_idx  = int'(a[AW:1]);
            m_din  = d;
          end
        end
      end
    end
    e_stall = m_have && (t + 1 > m_tacc) && (t + 1 < m_tacc + L);
    e_done  = m_have && (t + 1 == m_tacc + L);
    t++;
  endtask

  task automatic cmp(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, t);
    end
  endtask

  task automatic step(input bit r, rd, wr,
                      input logic [15:0] a, d, input bit chk);
    rst = r; Rd = rd; Wr = wr; Addr = a; DataIn = d;
    @(posedge clk);
    model_edge(r, rd, wr, a, d);
    @(negedge clk);
    if (chk) begin
      cmp("stall", 16'(Stall), 16'(e_stall));
      cmp("done", 16'(Done), 16'(e_done));
      cmp("err", 16'(err), 16'(e_err));
      cmp("dout", DataOut, e_dout);
    end
  endtask

  task automatic add(input bit r, rd, wr, input logic [15:0] a, d,
                     input bit st, dn, er, input logic [15:0] o);
    tbl.push_back(vec_t'{r, rd, wr, a, d, st, dn, er, o});
  endtask

  task automatic idl(input int n, input bit st, dn,
                     input logic [15:0] o);
    for (int k = 0; k < n; k++) add(0, 0, 0, 0, 0, st, dn, 0, o);
  endtask

  int          ndone;
  logic [15:0] ra;

  initial begin
    // write/read round trip
    add(0, 0, 1, 16'h0010, 16'hBEEF, 1, 0, 0, 16'h0000);
    idl(2, 1, 0, 16'h0000);
    idl(1, 0, 1, 16'h0000);
    idl(1, 0, 0, 16'h0000);
    add(0, 1, 0, 16'h0010, 0, 1, 0, 0, 16'h0000);
    idl(2, 1, 0, 16'h0000);
    idl(1, 0, 1, 16'hBEEF);
    // back-to-back write then read in Done cycle
    add(0, 0, 1, 16'h0020, 16'h1234, 1, 0, 0, 16'hBEEF);
    idl(2, 1, 0, 16'hBEEF);
    idl(1, 0, 1, 16'hBEEF);
    add(0, 1, 0, 16'h0020, 0, 1, 0, 0, 16'hBEEF);
    idl(2, 1, 0, 16'hBEEF);
    idl(1, 0, 1, 16'h1234);
    // illegal requests
    add(0, 1, 1, 16'h0004, 16'hFFFF, 0, 0, 1, 16'h1234);
    idl(1, 0, 0, 16'h1234);
    add(0, 1, 0, 16'h0003, 0, 0, 0, 1, 16'h1234);
    idl(1, 0, 0, 16'h1234);
    add(0, 1, 0, 16'h0004, 0, 1, 0, 0, 16'h1234);
    idl(2, 1, 0, 16'h1234);
    idl(1, 0, 1, 16'h100E);
    // alias / wrap
    add(0, 0, 1, 16'h0202, 16'hA5A5, 1, 0, 0, 16'h100E);
    idl(2, 1, 0, 16'h100E);
    idl(1, 0, 1, 16'h100E);
    add(0, 1, 0, 16'h0002, 0, 1, 0, 0, 16'h100E);
    idl(2, 1, 0, 16'h100E);
    idl(1, 0, 1, 16'hA5A5);
    // reset mid-write
    add(0, 0, 1, 16'h0040, 16'h5555, 1, 0, 0, 16'hA5A5);
    idl(1, 1, 0, 16'hA5A5);
    add(1, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
    idl(2, 0, 0, 16'h0000);
    add(0, 1, 0, 16'h0040, 0, 1, 0, 0, 16'h0000);
    idl(2, 1, 0, 16'h0000);
    idl(1, 0, 1, 16'h10E0);

    @(negedge clk);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    // preload every word: word i = 16'h1000 + 7*i
    for (int i = 0; i < 2**AW; i++) begin
      step(0, 0, 1, 16'(i * 2), 16'(16'h1000 + i * 7), 1);
      for (int k = 0; k < L - 1; k++) step(0, 0, 0, 0, 0, 1);
    end
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, 0);
      cmp($sformatf("v%0d_stall", i), 16'(Stall), 16'(tbl[i].st));
      cmp($sformatf("v%0d_done", i), 16'(Done), 16'(tbl[i].dn));
      cmp($sformatf("v%0d_err", i), 16'(err), 16'(tbl[i].er));
      cmp($sformatf("v%0d_dout", i), DataOut, tbl[i].dout);
    end

    // inputs toggled while busy are ignored
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 16'h0060, 16'h7777, 1);
    ndone = 0;
    for (int k = 0; k < L + 2; k++) begin
      if (k < L - 1)
        step(0, 1'($urandom), 1'($urandom), 16'($urandom),
             16'($urandom), 1);
      else
        step(0, 0, 0, 0, 0, 1);
      ndone += int'(Done);
    end
    cmp("busy_done_cnt", 16'(ndone), 16'd1);
    step(0, 1, 0, 16'h0060, 0, 1);
    for (int k = 0; k < L - 1; k++) step(0, 0, 0, 0, 0, 1);
    cmp("busy_rd_done", 16'(Done), 16'd1);
    cmp("busy_rd_data", DataOut, 16'h7777);

    // reset exactly on the commit edge drops the write
    step(0, 0, 1, 16'h0070, 16'h6666, 1);
    for (int k = 0; k < L - 2; k++) step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    step(0, 1, 0, 16'h0070, 0, 1);
    for (int k = 0; k < L - 1; k++) step(0, 0, 0, 0, 0, 1);
    cmp("rst_commit_data", DataOut, 16'h1000 + 16'd56 * 16'd7);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      ra = 16'($urandom);
      if ($urandom_range(7) != 0) ra[0] = 1'b0;
      step($urandom_range(63) == 0, $urandom_range(2) == 0,
           $urandom_range(2) == 0, ra, 16'($urandom), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
